prbs_checker: RTL
=================

// Module: prbs_checker
// PURPOSE
//  Receive-side companion to the 16-bit LFSR stimulus generator used by the filter test paths.
//  Polynomial: x^16+x^14+x^13+x^11+1.
//  Accepts one LFSR state word per enabled cycle, self-synchronises to the sequence and
//  declares lock. Then free-runs its own expected sequence and counts mismatched words.
//  Sits at the far end of a datapath under test (FIFO, link, loopback) to prove bit-exact transport.
// PARAMETERS
//  LOCK_CNT  4   consecutive matching words after the seed word required to assert locked
//  LOSS_CNT  3   consecutive mismatching words in LOCKED that force return to SEARCH
//  CNT_W     32  width of err_cnt and word_cnt (both saturate at all-ones)
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  rst       in   1      synchronous, active-low reset
//  en        in   1      data_in valid this cycle; nothing advances when low
//  data_in   in   16     received LFSR state word
//  clr_cnt   in   1      synchronous clear of err_cnt and word_cnt
//  locked    out  1      high while FSM is in LOCKED
//  err_pulse out  1      one-cycle pulse, registered, for each mismatching word while LOCKED
//  err_cnt   out  CNT_W  mismatching words seen while LOCKED, saturating
//  word_cnt  out  CNT_W  words (en=1) consumed while LOCKED, saturating
// BEHAVIOUR
//  next(x) = {x[14:0], x[15]^x[13]^x[12]^x[10]}. Example: 0x0001->0x0002->...->0x0400->0x0801.
//  Reset (rst==0 at edge): state=SEARCH, expected=0, match_cnt=0, bad_cnt=0.
//    All outputs 0. Reset mid-operation discards lock immediately.
//  en==0: state, expected, match_cnt, bad_cnt and counters hold. err_pulse=0.
//  SEARCH (en=1):
//    - data_in==0: illegal LFSR state, stay.
//    - Otherwise: expected<=next(data_in), match_cnt<=0, go VERIFY.
//  VERIFY (en=1):
//    - data_in==expected: expected<=next(data_in), match_cnt++.
//      On LOCK_CNT-th match, go LOCKED and clear bad_cnt.
//    - Mismatch, nonzero: reseed (expected<=next(data_in), match_cnt<=0), stay VERIFY.
//    - Mismatch, zero: go SEARCH.
//  LOCKED (en=1):
//    - expected<=next(expected) always; free-running, never reseeded from data_in,
//      so one bad word costs one error.
//    - Match: bad_cnt<=0, word_cnt++.
//    - Mismatch: err_pulse=1 next cycle, err_cnt++, word_cnt++, bad_cnt++.
//    - bad_cnt reaching LOSS_CNT: go SEARCH. locked low from the next cycle.
//      The losing word is still counted.
//  Lock latency: seed word plus LOCK_CNT matching words.
//    locked is high the cycle after the edge that consumes the last of these.
//    With en continuous and LOCK_CNT=4, that is 5 words.
//  Counters: no increment at all-ones.
//    clr_cnt=1 zeroes both counters and wins over a coincident increment.
//    err_pulse still fires for that word. clr_cnt does not affect FSM or lock.
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1. Reset, then 0x0001,0x0002,0x0004,0x0008,0x0010 with en=1 -> locked=1 after 5th edge.
//     Continue 1000 words -> err_cnt=0, word_cnt=1000.
//  2. Locked; XOR one word with 0x0001 -> err_pulse 1 cycle, err_cnt=1.
//     locked stays 1, subsequent correct words give no errors.
//  3. Locked; corrupt 3 consecutive words -> err_cnt=3, locked=0 next cycle.
//     Resume valid stream -> relock after 5 words.
//  4. Feed 0x0000 for 50 cycles after reset -> locked=0, state SEARCH throughout.
//     Then 0x0001... -> locks normally.
//  5. Valid stream with random en gaps (~50% duty) -> locks after 5 enabled words.
//     err_cnt=0, word_cnt equals enabled words in LOCKED.
//  6. rst=0 for 1 cycle mid-LOCKED -> all outputs 0 next cycle.
//     clr_cnt with a corrupt word -> err_cnt=0, err_pulse=1.
//     CNT_W=4 with 20 errors -> err_cnt holds 15.

Source files
------------

// File: rtl/prbs_checker.sv
// Receive-side checker for the x^16+x^14+x^13+x^11+1 LFSR stream: self-synchronises,
// declares lock, then free-runs its own sequence and counts mismatching words.
module prbs_checker #(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [15:0]      data_in,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] word_cnt
);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned BAD_W   = $clog2(LOSS_CNT + 1);

   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
   localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
   localparam logic [BAD_W-1:0]   BAD_LAST   = BAD_W'(LOSS_CNT - 1);
   localparam logic [BAD_W-1:0]   BAD_ONE    = BAD_W'(1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   logic [1:0]         state_q, state_d;
   logic [15:0]        expected_q, expected_d;
   logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
   logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
   logic               locked_q, locked_d;
   logic               err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic               word_inc, err_inc;

   // Sync FSM and expected-word tracking
   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      match_cnt_d = match_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      word_inc    = 1'b0;
      err_inc     = 1'b0;
      if (en) begin
         unique case (state_q)
            ST_SEARCH: begin
               if (data_in != 16'h0000) begin
                  expected_d  = lfsr_next(data_in);
                  match_cnt_d = '0;
                  state_d     = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (data_in == expected_q) begin
                  expected_d = lfsr_next(data_in);
                  if (match_cnt_q == MATCH_LAST) begin
                     state_d     = ST_LOCKED;
                     match_cnt_d = '0;
                     bad_cnt_d   = '0;
                  end else begin
                     match_cnt_d = match_cnt_q + MATCH_ONE;
                  end
               end else if (data_in != 16'h0000) begin
                  expected_d  = lfsr_next(data_in);
                  match_cnt_d = '0;
               end else begin
                  state_d = ST_SEARCH;
               end
            end
            ST_LOCKED: begin
               // Never reseed here, so a single corrupted word costs exactly one error
               expected_d = lfsr_next(expected_q);
               word_inc   = 1'b1;
               if (data_in == expected_q) begin
                  bad_cnt_d = '0;
               end else begin
                  err_inc = 1'b1;
                  if (bad_cnt_q == BAD_LAST) begin
                     state_d   = ST_SEARCH;
                     bad_cnt_d = '0;
                  end else begin
                     bad_cnt_d = bad_cnt_q + BAD_ONE;
                  end
               end
            end
            default: begin
               state_d = ST_SEARCH;
            end
         endcase
      end
   end

   // Saturating counters; clear takes priority over a coincident increment
   always_comb begin
      err_cnt_d  = err_cnt_q;
      word_cnt_d = word_cnt_q;
      if (clr_cnt) begin
         err_cnt_d  = '0;
         word_cnt_d = '0;
      end else begin
         if (word_inc && (word_cnt_q != CNT_MAX)) begin
            word_cnt_d = word_cnt_q + CNT_ONE;
         end
         if (err_inc && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
         end
      end
      err_pulse_d = err_inc;
      locked_d    = (state_d == ST_LOCKED);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_SEARCH;
         expected_q  <= '0;
         match_cnt_q <= '0;
         bad_cnt_q   <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_cnt_q   <= '0;
         word_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         match_cnt_q <= match_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_cnt_q   <= err_cnt_d;
         word_cnt_q  <= word_cnt_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
   assign word_cnt  = word_cnt_q;

endmodule
